// File: rtl/mcu_dbg_responder.sv
// ---------------------------------------------------------------------------
// mcu_dbg_responder
//
// MCU-side endpoint of the debugger command interface. It takes single-cycle
// command strobes from the debug controller and drives the core's halt,
// reset, register-file and data-memory debug ports. Completion is signalled
// by mcu_busy falling. Read results land in dbg_rdata.
//
// Parameters:
//   RESET_CYCLES  cycles core_reset stays high for a reset command (>=1)
//   MEM_TIMEOUT   cycles to wait for dmem_ready before aborting
//                 (only used when DBG_MEM_TIMEOUT_EN is defined)
//
// Optional build macro:
//   DBG_MEM_TIMEOUT_EN  when defined, a memory access with no dmem_ready
//                       after MEM_TIMEOUT cycles is aborted with dbg_err=1.
//                       When undefined, memory accesses wait indefinitely.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   dbg_valid                      command strobe
//   dbg_pause/resume/reset         run-control command bits
//   dbg_reg_rd/reg_wr/mem_rd/mem_wr access command bits
//   dbg_mem_be                     4'hF = word access, one-hot = byte access
//   dbg_addr, dbg_wdata            address / register index, write data
//   mcu_busy, dbg_rdata, dbg_err   status and read result
//   dbg_pc                         core_pc captured when the halt completes
//   core_halt_req, core_reset      run control towards the core
//   core_halted, core_pc           status from the core
//   rf_addr/rf_wdata/rf_we/rf_rdata register-file debug port
//   dmem_addr/wdata/be/re/we       data-memory debug port (request)
//   dmem_rdata, dmem_ready         data-memory debug port (response)
// ---------------------------------------------------------------------------
module mcu_dbg_responder #(
  parameter int RESET_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dbg_valid,
  input  logic        dbg_pause,
  input  logic        dbg_resume,
  input  logic        dbg_reset,
  input  logic        dbg_reg_rd,
  input  logic        dbg_reg_wr,
  input  logic        dbg_mem_rd,
  input  logic        dbg_mem_wr,
  input  logic [3:0]  dbg_mem_be,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        mcu_busy,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic [31:0] dbg_pc,
  output logic        core_halt_req,
  input  logic        core_halted,
  output logic        core_reset,
  input  logic [31:0] core_pc,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  output logic        rf_we,
  input  logic [31:0] rf_rdata,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        dmem_re,
  output logic        dmem_we,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HALT   = 3'd1;
  localparam logic [2:0] S_RESUME = 3'd2;
  localparam logic [2:0] S_RESET  = 3'd3;
  localparam logic [2:0] S_REG    = 3'd4;
  localparam logic [2:0] S_MEM    = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  // The counter only has to hold RESET_CYCLES-1; with the timeout enabled it
  // also counts memory wait cycles and is at least 8 bits wide.
  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
`ifdef DBG_MEM_TIMEOUT_EN
  localparam int TO_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int TO_W   = (TO_RAW > 8) ? TO_RAW : 8;
  localparam int CNT_W  = (TO_W > RST_W) ? TO_W : RST_W;
`else
  localparam int CNT_W  = RST_W;
`endif

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             halted;
  logic             op_write;
  logic             op_byte;
  logic [1:0]       lane;
  logic             cmd_any;
  logic [7:0]       lane_byte;

  // A strobe with no command bit set is not a command at all and is dropped.
  always_comb begin
    cmd_any = dbg_pause | dbg_resume | dbg_reset | dbg_reg_rd | dbg_reg_wr |
              dbg_mem_rd | dbg_mem_wr;
  end

  // Byte lane picked by the address latched at acceptance, used to build the
  // zero-extended result of a byte read.
  always_comb begin
    lane_byte = dmem_rdata[7:0];
    case (lane)
      2'd1:    lane_byte = dmem_rdata[15:8];
      2'd2:    lane_byte = dmem_rdata[23:16];
      2'd3:    lane_byte = dmem_rdata[31:24];
      default: lane_byte = dmem_rdata[7:0];
    endcase
  end

  // Main command FSM. Everything the command needs is captured on the
  // acceptance edge, so the controller is free to change its inputs while
  // we are busy. Core-side strobes are registers and so fall asynchronously
  // with rst_n. core_halt_req and the halted flag are deliberately left alone
  // by the reset command so a halted core comes out of reset still halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      halted        <= 1'b0;
      op_write      <= 1'b0;
      op_byte       <= 1'b0;
      lane          <= 2'd0;
      mcu_busy      <= 1'b0;
      dbg_rdata     <= 32'h0;
      dbg_err       <= 1'b0;
      dbg_pc        <= 32'h0;
      core_halt_req <= 1'b0;
      core_reset    <= 1'b0;
      rf_addr       <= 5'd0;
      rf_wdata      <= 32'h0;
      rf_we         <= 1'b0;
      dmem_addr     <= 32'h0;
      dmem_wdata    <= 32'h0;
      dmem_be       <= 4'h0;
      dmem_re       <= 1'b0;
      dmem_we       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dbg_valid && cmd_any) begin
            mcu_busy <= 1'b1;
            dbg_err  <= 1'b0;
            if (dbg_reset) begin
              core_reset <= 1'b1;
              cnt        <= CNT_W'(RESET_CYCLES - 1);
              state      <= S_RESET;
            end else if (dbg_pause) begin
              core_halt_req <= 1'b1;
              state         <= S_HALT;
            end else if (dbg_resume) begin
              state <= S_RESUME;
            end else if (dbg_mem_wr || dbg_mem_rd) begin
              if (!halted) begin
                state <= S_ERR;
              end else begin
                op_write  <= dbg_mem_wr;
                op_byte   <= (dbg_mem_be != 4'hF);
                lane      <= dbg_addr[1:0];
                dmem_addr <= {dbg_addr[31:2], 2'b00};
                if (dbg_mem_be == 4'hF) begin
                  dmem_be    <= 4'hF;
                  dmem_wdata <= dbg_wdata;
                end else begin
                  dmem_be    <= 4'b0001 << dbg_addr[1:0];
                  dmem_wdata <= {4{dbg_wdata[7:0]}};
                end
                dmem_we <= dbg_mem_wr;
                dmem_re <= ~dbg_mem_wr;
                cnt     <= '0;
                state   <= S_MEM;
              end
            end else begin
              if (!halted) begin
                state <= S_ERR;
              end else begin
                op_write <= dbg_reg_wr;
                rf_addr  <= dbg_addr[4:0];
                rf_wdata <= dbg_wdata;
                rf_we    <= dbg_reg_wr && (dbg_addr[4:0] != 5'd0);
                state    <= S_REG;
              end
            end
          end
        end

        S_HALT: begin
          if (core_halted || halted) begin
            dbg_pc   <= core_pc;
            halted   <= 1'b1;
            mcu_busy <= 1'b0;
            state    <= S_IDLE;
          end
        end

        S_RESUME: begin
          core_halt_req <= 1'b0;
          halted        <= 1'b0;
          mcu_busy      <= 1'b0;
          state         <= S_IDLE;
        end

        S_RESET: begin
          if (cnt == '0) begin
            core_reset <= 1'b0;
            mcu_busy   <= 1'b0;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_REG: begin
          rf_we <= 1'b0;
          if (!op_write) begin
            dbg_rdata <= rf_rdata;
          end
          mcu_busy <= 1'b0;
          state    <= S_IDLE;
        end

        S_MEM: begin
          if (dmem_ready) begin
            dmem_re <= 1'b0;
            dmem_we <= 1'b0;
            if (!op_write) begin
              dbg_rdata <= op_byte ? {24'h0, lane_byte} : dmem_rdata;
            end
            mcu_busy <= 1'b0;
            state    <= S_IDLE;
          end
`ifdef DBG_MEM_TIMEOUT_EN
          else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            dmem_re <= 1'b0;
            dmem_we <= 1'b0;
            dbg_err <= 1'b1;
            if (!op_write) begin
              dbg_rdata <= 32'h0;
            end
            mcu_busy <= 1'b0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end

        S_ERR: begin
          dbg_err  <= 1'b1;
          mcu_busy <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          mcu_busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_dbg_responder.sv
// ---------------------------------------------------------------------------
// tb_mcu_dbg_responder
//
// Directed bench for mcu_dbg_responder. Each scenario task drives one
// command sequence and compares outputs against hand-computed values.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_mcu_dbg_responder;

  localparam int RESET_CYCLES = 4;
  localparam int MEM_TIMEOUT  = 16;

  localparam logic [6:0] C_RESET  = 7'b1000000;
  localparam logic [6:0] C_PAUSE  = 7'b0100000;
  localparam logic [6:0] C_RESUME = 7'b0010000;
  localparam logic [6:0] C_MEMWR  = 7'b0001000;
  localparam logic [6:0] C_MEMRD  = 7'b0000100;
  localparam logic [6:0] C_REGWR  = 7'b0000010;
  localparam logic [6:0] C_REGRD  = 7'b0000001;

  logic        clk;
  logic        rst_n;
  logic        dbg_valid;
  logic        dbg_pause, dbg_resume, dbg_reset;
  logic        dbg_reg_rd, dbg_reg_wr, dbg_mem_rd, dbg_mem_wr;
  logic [3:0]  dbg_mem_be;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        mcu_busy;
  logic [31:0] dbg_rdata;
  logic        dbg_err;
  logic [31:0] dbg_pc;
  logic        core_halt_req;
  logic        core_halted;
  logic        core_reset;
  logic [31:0] core_pc;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        rf_we;
  logic [31:0] rf_rdata;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_re;
  logic        dmem_we;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic [175:0] all_out;

  int checks   = 0;
  int failures = 0;

  mcu_dbg_responder #(
    .RESET_CYCLES(RESET_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dbg_valid    (dbg_valid),
    .dbg_pause    (dbg_pause),
    .dbg_resume   (dbg_resume),
    .dbg_reset    (dbg_reset),
    .dbg_reg_rd   (dbg_reg_rd),
    .dbg_reg_wr   (dbg_reg_wr),
    .dbg_mem_rd   (dbg_mem_rd),
    .dbg_mem_wr   (dbg_mem_wr),
    .dbg_mem_be   (dbg_mem_be),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .mcu_busy     (mcu_busy),
    .dbg_rdata    (dbg_rdata),
    .dbg_err      (dbg_err),
    .dbg_pc       (dbg_pc),
    .core_halt_req(core_halt_req),
    .core_halted  (core_halted),
    .core_reset   (core_reset),
    .core_pc      (core_pc),
    .rf_addr      (rf_addr),
    .rf_wdata     (rf_wdata),
    .rf_we        (rf_we),
    .rf_rdata     (rf_rdata),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_re      (dmem_re),
    .dmem_we      (dmem_we),
    .dmem_rdata   (dmem_rdata),
    .dmem_ready   (dmem_ready)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in: x5 holds 0x77, every other index reads 0xBAD00000.
  assign rf_rdata = (rf_addr == 5'd5) ? 32'h0000_0077 : 32'hBAD0_0000;

  // Every output concatenated, so reset can be checked in one comparison.
  assign all_out = {mcu_busy, dbg_rdata, dbg_err, dbg_pc, core_halt_req,
                    core_reset, rf_addr, rf_wdata, rf_we, dmem_addr,
                    dmem_wdata, dmem_be, dmem_re, dmem_we};

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for exactly one accepting edge, then drop the strobe
  // and command bits. Returns 1 unit after that edge (first busy cycle).
  task automatic applyStimulus(input logic [6:0] cmd, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    {dbg_reset, dbg_pause, dbg_resume, dbg_mem_wr, dbg_mem_rd, dbg_reg_wr,
     dbg_reg_rd} = cmd;
    dbg_valid  = 1'b1;
    dbg_addr   = addr;
    dbg_wdata  = wdata;
    dbg_mem_be = be;
    tick();
    dbg_valid = 1'b0;
    {dbg_reset, dbg_pause, dbg_resume, dbg_mem_wr, dbg_mem_rd, dbg_reg_wr,
     dbg_reg_rd} = 7'b0;
  endtask

  // Count cycles while busy, starting with the current one; bounded.
  task automatic busy_len(output int n);
    n = 0;
    while (mcu_busy && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {dbg_valid, dbg_pause, dbg_resume, dbg_reset} = 4'b0;
    {dbg_reg_rd, dbg_reg_wr, dbg_mem_rd, dbg_mem_wr} = 4'b0;
    dbg_mem_be  = 4'h0;
    dbg_addr    = 32'h0;
    dbg_wdata   = 32'h0;
    core_halted = 1'b0;
    core_pc     = 32'h8000_0040;
    dmem_rdata  = 32'h0;
    dmem_ready  = 1'b0;
    tick();
    tick();
    checks++;
    if (all_out !== 176'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", all_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_running_access();
    int n;
    applyStimulus(C_REGRD, 32'd5, 32'h0, 4'hF);
    checks++;
    if ({mcu_busy, rf_we, dmem_re, dmem_we} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL run_regrd_activity: got %b expected 1000",
               {mcu_busy, rf_we, dmem_re, dmem_we});
    end
    busy_len(n);
    checks++;
    if (n != 1) begin
      failures++;
      $display("[TB] FAIL run_regrd_busy_len: got %0d expected 1", n);
    end
    checks++;
    if ({dbg_err, dbg_rdata} !== {1'b1, 32'h0}) begin
      failures++;
      $display("[TB] FAIL run_regrd_err: got err=%b rdata=%h expected err=1 rdata=0",
               dbg_err, dbg_rdata);
    end
    applyStimulus(C_MEMWR, 32'h2000, 32'h1, 4'hF);
    checks++;
    if (dmem_we !== 1'b0) begin
      failures++;
      $display("[TB] FAIL run_memwr_we: got %b expected 0", dmem_we);
    end
    tick();
    checks++;
    if ({mcu_busy, dbg_err} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL run_memwr_err: got busy,err=%b expected 01", {mcu_busy, dbg_err});
    end
    // Strobe with no command bits: not accepted, dbg_err keeps its 1.
    applyStimulus(7'b0, 32'h0, 32'h0, 4'hF);
    checks++;
    if ({mcu_busy, dbg_err} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL empty_cmd: got busy,err=%b expected 01", {mcu_busy, dbg_err});
    end
  endtask

  task automatic test_pause();
    int n;
    applyStimulus(C_PAUSE, 32'h0, 32'h0, 4'hF);
    checks++;
    if ({core_halt_req, mcu_busy, dbg_err} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL pause_start: got req,busy,err=%b expected 110",
               {core_halt_req, mcu_busy, dbg_err});
    end
    tick();
    tick();
    tick();
    checks++;
    if (mcu_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pause_busy_4th: got %b expected 1", mcu_busy);
    end
    core_halted = 1'b1;
    tick();
    checks++;
    if ({mcu_busy, core_halt_req, dbg_pc} !== {2'b01, 32'h8000_0040}) begin
      failures++;
      $display("[TB] FAIL pause_done: got busy=%b req=%b pc=%h expected busy=0 req=1 pc=80000040",
               mcu_busy, core_halt_req, dbg_pc);
    end
    applyStimulus(C_PAUSE, 32'h0, 32'h0, 4'hF);
    busy_len(n);
    checks++;
    if (n != 1) begin
      failures++;
      $display("[TB] FAIL pause_again_len: got %0d expected 1", n);
    end
  endtask

  task automatic test_mem_word_read();
    applyStimulus(C_MEMRD, 32'h0000_1004, 32'h0, 4'hF);
    checks++;
    if ({dmem_re, dmem_we, dmem_addr, dmem_be} !== {2'b10, 32'h1004, 4'hF}) begin
      failures++;
      $display("[TB] FAIL word_rd_req: got re=%b we=%b addr=%h be=%h expected re=1 we=0 addr=1004 be=f",
               dmem_re, dmem_we, dmem_addr, dmem_be);
    end
    tick();
    checks++;
    if ({mcu_busy, dmem_re} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL word_rd_hold: got busy,re=%b expected 11", {mcu_busy, dmem_re});
    end
    dmem_rdata = 32'hCAFE_BABE;
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    checks++;
    if ({mcu_busy, dmem_re, dbg_rdata} !== {2'b00, 32'hCAFE_BABE}) begin
      failures++;
      $display("[TB] FAIL word_rd_done: got busy=%b re=%b rdata=%h expected 0 0 cafebabe",
               mcu_busy, dmem_re, dbg_rdata);
    end
  endtask

  task automatic test_mem_byte();
    applyStimulus(C_MEMWR, 32'h0000_2003, 32'h1234_565A, 4'b0001);
    checks++;
    if ({dmem_we, dmem_re, dmem_addr, dmem_be, dmem_wdata} !==
        {2'b10, 32'h2000, 4'b1000, 32'h5A5A_5A5A}) begin
      failures++;
      $display("[TB] FAIL byte_wr_req: got we=%b re=%b addr=%h be=%b wdata=%h expected 1 0 2000 1000 5a5a5a5a",
               dmem_we, dmem_re, dmem_addr, dmem_be, dmem_wdata);
    end
    // Inputs wander and a reset command arrives while busy: both ignored.
    dbg_addr  = 32'hFFFF_FFF0;
    dbg_wdata = 32'h0;
    dbg_valid = 1'b1;
    dbg_reset = 1'b1;
    tick();
    dbg_valid = 1'b0;
    dbg_reset = 1'b0;
    checks++;
    if ({core_reset, dmem_we, dmem_addr, dmem_wdata} !== {2'b01, 32'h2000, 32'h5A5A_5A5A}) begin
      failures++;
      $display("[TB] FAIL byte_wr_hold: got rst=%b we=%b addr=%h wdata=%h expected 0 1 2000 5a5a5a5a",
               core_reset, dmem_we, dmem_addr, dmem_wdata);
    end
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    checks++;
    if ({mcu_busy, dmem_we, dbg_rdata} !== {2'b00, 32'hCAFE_BABE}) begin
      failures++;
      $display("[TB] FAIL byte_wr_done: got busy=%b we=%b rdata=%h expected 0 0 cafebabe",
               mcu_busy, dmem_we, dbg_rdata);
    end
    applyStimulus(C_MEMRD, 32'h0000_3001, 32'h0, 4'b0100);
    checks++;
    if ({dmem_addr, dmem_be} !== {32'h3000, 4'b0010}) begin
      failures++;
      $display("[TB] FAIL byte_rd_req: got addr=%h be=%b expected 3000 0010", dmem_addr, dmem_be);
    end
    dmem_rdata = 32'h1122_3344;
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    checks++;
    if (dbg_rdata !== 32'h0000_0033) begin
      failures++;
      $display("[TB] FAIL byte_rd_data: got %h expected 00000033", dbg_rdata);
    end
  endtask

  task automatic test_reg();
    applyStimulus(C_REGWR, 32'd0, 32'h1234, 4'hF);
    checks++;
    if ({mcu_busy, rf_we} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL reg_wr_x0: got busy,we=%b expected 10", {mcu_busy, rf_we});
    end
    tick();
    applyStimulus(C_REGWR, 32'd3, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if ({rf_we, rf_addr, rf_wdata} !== {1'b1, 5'd3, 32'hDEAD_BEEF}) begin
      failures++;
      $display("[TB] FAIL reg_wr_x3: got we=%b addr=%0d wdata=%h expected 1 3 deadbeef",
               rf_we, rf_addr, rf_wdata);
    end
    tick();
    checks++;
    if ({rf_we, mcu_busy, dbg_err} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reg_wr_done: got we,busy,err=%b expected 000", {rf_we, mcu_busy, dbg_err});
    end
    applyStimulus(C_REGRD, 32'd5, 32'h0, 4'hF);
    checks++;
    if (dbg_rdata !== 32'h0000_0033) begin
      failures++;
      $display("[TB] FAIL reg_rd_early: got %h expected 00000033", dbg_rdata);
    end
    tick();
    checks++;
    if ({mcu_busy, dbg_rdata} !== {1'b0, 32'h0000_0077}) begin
      failures++;
      $display("[TB] FAIL reg_rd_x5: got busy=%b rdata=%h expected 0 00000077", mcu_busy, dbg_rdata);
    end
  endtask

  task automatic test_priority();
    applyStimulus(C_MEMRD | C_REGRD | C_REGWR, 32'h0000_4008, 32'h0, 4'hF);
    checks++;
    if ({dmem_re, rf_we, dmem_addr} !== {2'b10, 32'h4008}) begin
      failures++;
      $display("[TB] FAIL prio_mem_over_reg: got re=%b rf_we=%b addr=%h expected 1 0 4008",
               dmem_re, rf_we, dmem_addr);
    end
    dmem_rdata = 32'h0BAD_F00D;
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    checks++;
    if (dbg_rdata !== 32'h0BAD_F00D) begin
      failures++;
      $display("[TB] FAIL prio_mem_data: got %h expected 0badf00d", dbg_rdata);
    end
  endtask

  task automatic test_reset_cmd();
    int n;
    applyStimulus(C_RESET | C_PAUSE, 32'h0, 32'h0, 4'hF);
    n = 0;
    while (core_reset && n < 50) begin
      n++;
      tick();
    end
    checks++;
    if (n != RESET_CYCLES) begin
      failures++;
      $display("[TB] FAIL reset_cmd_len: got %0d expected %0d", n, RESET_CYCLES);
    end
    checks++;
    if ({mcu_busy, core_halt_req} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL reset_cmd_after: got busy,req=%b expected 01", {mcu_busy, core_halt_req});
    end
    applyStimulus(C_REGRD, 32'd7, 32'h0, 4'hF);
    tick();
    checks++;
    if ({dbg_err, dbg_rdata} !== {1'b0, 32'hBAD0_0000}) begin
      failures++;
      $display("[TB] FAIL reset_keeps_halt: got err=%b rdata=%h expected 0 bad00000", dbg_err, dbg_rdata);
    end
  endtask

  task automatic test_resume();
    applyStimulus(C_RESUME | C_MEMWR, 32'h0, 32'h0, 4'hF);
    checks++;
    if ({core_halt_req, mcu_busy, dmem_we} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL resume_start: got req,busy,we=%b expected 110",
               {core_halt_req, mcu_busy, dmem_we});
    end
    tick();
    core_halted = 1'b0;
    checks++;
    if ({core_halt_req, mcu_busy} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL resume_done: got req,busy=%b expected 00", {core_halt_req, mcu_busy});
    end
    applyStimulus(C_REGRD, 32'd5, 32'h0, 4'hF);
    tick();
    checks++;
    if (dbg_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL resume_clears_halt: got err=%b expected 1", dbg_err);
    end
  endtask

  task automatic test_back_to_back();
    core_halted = 1'b1;
    applyStimulus(C_PAUSE, 32'h0, 32'h0, 4'hF);
    tick();
    applyStimulus(C_RESUME, 32'h0, 32'h0, 4'hF);
    tick();
    core_halted = 1'b0;
    checks++;
    if ({mcu_busy, core_halt_req} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL step_resume: got busy,req=%b expected 00", {mcu_busy, core_halt_req});
    end
    applyStimulus(C_PAUSE, 32'h0, 32'h0, 4'hF);
    checks++;
    if ({mcu_busy, core_halt_req} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL step_pause: got busy,req=%b expected 11", {mcu_busy, core_halt_req});
    end
    core_halted = 1'b1;
    tick();
    checks++;
    if (mcu_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL step_halted: got busy=%b expected 0", mcu_busy);
    end
  endtask

  task automatic test_mem_wait();
    int n;
    applyStimulus(C_MEMRD, 32'h0000_5000, 32'h0, 4'hF);
`ifdef DBG_MEM_TIMEOUT_EN
    busy_len(n);
    checks++;
    if (n != MEM_TIMEOUT) begin
      failures++;
      $display("[TB] FAIL timeout_len: got %0d expected %0d", n, MEM_TIMEOUT);
    end
    checks++;
    if ({dbg_err, dmem_re, dbg_rdata} !== {2'b10, 32'h0}) begin
      failures++;
      $display("[TB] FAIL timeout_abort: got err=%b re=%b rdata=%h expected 1 0 0",
               dbg_err, dmem_re, dbg_rdata);
    end
`else
    n = 0;
    repeat (40) begin
      tick();
      n++;
    end
    checks++;
    if ({mcu_busy, dmem_re} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL mem_wait_%0d: got busy,re=%b expected 11", n, {mcu_busy, dmem_re});
    end
    dmem_rdata = 32'h600D_CAFE;
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    checks++;
    if ({mcu_busy, dbg_err, dbg_rdata} !== {2'b00, 32'h600D_CAFE}) begin
      failures++;
      $display("[TB] FAIL mem_wait_done: got busy=%b err=%b rdata=%h expected 0 0 600dcafe",
               mcu_busy, dbg_err, dbg_rdata);
    end
`endif
  endtask

  task automatic test_async_reset();
    applyStimulus(C_MEMWR, 32'h0000_6000, 32'hAA, 4'hF);
    checks++;
    if (dmem_we !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_pre_we: got %b expected 1", dmem_we);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== 176'h0) begin
      failures++;
      $display("[TB] FAIL async_reset_outputs: got %h expected 0", all_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(C_REGRD, 32'd5, 32'h0, 4'hF);
    tick();
    checks++;
    if (dbg_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_reset_halt_flag: got err=%b expected 1", dbg_err);
    end
  endtask

  // Scenario sequence; each task leaves the block idle for the next one.
  initial begin
    test_reset();
    test_running_access();
    test_pause();
    test_mem_word_read();
    test_mem_byte();
    test_reg();
    test_priority();
    test_reset_cmd();
    test_resume();
    test_back_to_back();
    test_mem_wait();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
